// File: rtl/tinyalu_ctrl_pkg.sv
// tinyalu_ctrl_pkg
// Shared types and helpers for the TinyALU arbiter slice.
//   op_e      : 3-bit TinyALU opcode encoding
//   state_e   : arbiter FSM states
//   is_alu_op : true for opcodes that are actually sent to the ALU
package tinyalu_ctrl_pkg;

    typedef enum logic [2:0] {
        NOP = 3'b000,
        ADD = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    // NOP and the unused encodings 101..111 are answered locally and
    // never reach the ALU, so only these four count as real ALU work.
    function automatic logic is_alu_op(input logic [2:0] op);
        case (op)
            ADD, AND, XOR, MUL: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_arbiter_rr.sv
// rr_arbiter
// Purely combinational round-robin pick: the first set request bit at or
// after the pointer, wrapping around. The pointer itself is owned and
// advanced by the parent.
//   req   : request vector, one bit per requester
//   ptr   : index with the highest priority this cycle
//   grant : one-hot grant (all zero when no request is set)
//   idx   : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   pos;
    logic found;

    // Walk the requesters starting at the pointer; the found flag keeps
    // only the first hit so the grant stays one-hot.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter
// Shares one TinyALU between N requesters, granting round-robin and
// holding the ALU inputs stable until done (or a timeout) before sending
// the result back to the granted requester.
//   clk, reset_n           : clock, asynchronous active-low reset
//   req_valid/ready        : per-requester handshake (ready is combinational)
//   req_a/req_b/req_op     : packed per-requester operands and opcodes
//   rsp_valid/result/err   : one-cycle, one-hot completion to the requester
//   alu_start/a/b/op       : registered drive of the shared ALU
//   alu_done/alu_result    : completion from the ALU
//   busy                   : high whenever the FSM is not IDLE
module tinyalu_arbiter
    import tinyalu_ctrl_pkg::*;
#(
    parameter int N           = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*8-1:0] req_a,
    input  logic [N*8-1:0] req_b,
    input  logic [N*3-1:0] req_op,
    output logic [N-1:0]   rsp_valid,
    output logic [15:0]    rsp_result,
    output logic           rsp_err,
    output logic           alu_start,
    output logic [7:0]     alu_a,
    output logic [7:0]     alu_b,
    output logic [2:0]     alu_op,
    input  logic           alu_done,
    input  logic [15:0]    alu_result,
    output logic           busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT_CYC);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          alu_start_d;
    logic [7:0]    alu_a_d, alu_b_d;
    logic [2:0]    alu_op_d;
    logic [N-1:0]  rsp_valid_d;
    logic [15:0]   rsp_result_d;
    logic          rsp_err_d;
    logic          busy_d;

    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic [7:0]    sel_a, sel_b;
    logic [2:0]    sel_op;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // Only the IDLE state can accept, so the ready strobe is the grant
    // gated by the state.
    assign req_ready = gnt & {N{state_q == IDLE}};

    // One-hot AND-OR mux that picks the winner's operands and opcode.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_a  = sel_a  | req_a[8*i +: 8];
                sel_b  = sel_b  | req_b[8*i +: 8];
                sel_op = sel_op | req_op[3*i +: 3];
            end
        end
    end

    // Next-state and next-output logic. Every output is computed here and
    // registered below so that alu_* and rsp_* change only on clock edges.
    // The winner is kept one-hot so it can be copied straight to rsp_valid.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        alu_start_d  = alu_start;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_op_d     = alu_op;
        rsp_valid_d  = '0;
        rsp_result_d = '0;
        rsp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                alu_start_d = 1'b0;
                if (|req_valid) begin
                    win_d = gnt;
                    ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
                    if (is_alu_op(sel_op)) begin
                        state_d     = BUSY;
                        alu_start_d = 1'b1;
                        alu_a_d     = sel_a;
                        alu_b_d     = sel_b;
                        alu_op_d    = sel_op;
                        cnt_d       = '0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = gnt;
                        rsp_err_d   = (sel_op != NOP);
                    end
                end
            end
            BUSY: begin
                alu_start_d = 1'b1;
                if (alu_done) begin
                    state_d      = RESP;
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = win_q;
                    rsp_result_d = alu_result;
                    cnt_d        = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
                    state_d     = RESP;
                    alu_start_d = 1'b0;
                    rsp_valid_d = win_q;
                    rsp_err_d   = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                alu_start_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                alu_start_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight op silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            alu_start  <= alu_start_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_op     <= alu_op_d;
            rsp_valid  <= rsp_valid_d;
            rsp_result <= rsp_result_d;
            rsp_err    <= rsp_err_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter
// Directed self-checking bench for tinyalu_arbiter (N=4, TIMEOUT_CYC=16)
// with a small TinyALU model answering after 2 (ADD/AND/XOR) or 5 (MUL)
// start-high cycles.
module tb_tinyalu_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a = '0;
    logic [N*8-1:0] req_b = '0;
    logic [N*3-1:0] req_op = '0;
    logic [N-1:0]   rsp_valid;
    logic [15:0]    rsp_result;
    logic           rsp_err;
    logic           alu_start;
    logic [7:0]     alu_a, alu_b;
    logic [2:0]     alu_op;
    logic           alu_done;
    logic [15:0]    alu_result;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic alu_kill = 1'b0;
    int   alu_cnt;
    int   alu_need;

    int   min_gap = 1000;
    int   low_run = 0;
    logic prev_start = 1'b0;
    logic seen_start = 1'b0;

    tinyalu_arbiter #(.N(N), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // TinyALU model: counts start-high edges, raises done in the last
    // start-high cycle of the op; alu_kill models a hung ALU.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       alu_cnt <= 0;
        else if (alu_start) alu_cnt <= alu_cnt + 1;
        else                alu_cnt <= 0;
    end

    always_comb begin
        alu_need   = (alu_op == 3'b100) ? 5 : 2;
        alu_done   = alu_start && !alu_kill && (alu_cnt == alu_need - 1);
        alu_result = '0;
        case (alu_op)
            3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'b010:  alu_result = {8'h00, alu_a & alu_b};
            3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
            3'b100:  alu_result = {8'h00, alu_a} * {8'h00, alu_b};
            default: alu_result = '0;
        endcase
    end

    // Tracks the shortest run of start-low cycles between two ALU ops.
    always @(negedge clk) begin
        if (!reset_n) begin
            low_run    = 0;
            prev_start = 1'b0;
            seen_start = 1'b0;
        end else begin
            if (alu_start && !prev_start && seen_start && low_run < min_gap)
                min_gap = low_run;
            if (alu_start) begin
                seen_start = 1'b1;
                low_run    = 0;
            end else begin
                low_run = low_run + 1;
            end
            prev_start = alu_start;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_op[3*i +: 3] = op;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        step();
        step();
        checks++;
        if ({alu_start, alu_a, alu_b, alu_op, busy, rsp_valid, rsp_result, rsp_err, req_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got start=%b a=%h b=%h op=%h busy=%b rv=%b res=%h err=%b rdy=%b want all 0",
                     alu_start, alu_a, alu_b, alu_op, busy, rsp_valid, rsp_result, rsp_err, req_ready);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        set_req(0, 8'h05, 8'h03, 3'b001);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL add_ready got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({alu_start, alu_a, alu_b, alu_op, busy} !== {1'b1, 8'h05, 8'h03, 3'b001, 1'b1}) begin
            errors++; $display("[TB] FAIL add_cyc1 got start=%b a=%h b=%h op=%h busy=%b want 1 05 03 1 1",
                               alu_start, alu_a, alu_b, alu_op, busy);
        end
        step();
        checks++;
        if (alu_start !== 1'b1 || rsp_valid !== 4'b0000) begin
            errors++; $display("[TB] FAIL add_cyc2 got start=%b rv=%b want 1 0000", alu_start, rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_result, rsp_err, alu_start} !== {4'b0001, 16'h0008, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL add_rsp got rv=%b res=%h err=%b start=%b want 0001 0008 0 0",
                               rsp_valid, rsp_result, rsp_err, alu_start);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL add_after got rv=%b busy=%b want 0000 0", rsp_valid, busy);
        end
    endtask

    task automatic test_mul();
        set_req(2, 8'hFF, 8'hFF, 3'b100);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL mul_ready got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        set_req(2, 8'h11, 8'h22, 3'b001);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({alu_start, alu_a, alu_b, alu_op, rsp_valid} !== {1'b1, 8'hFF, 8'hFF, 3'b100, 4'b0000}) begin
                errors++; $display("[TB] FAIL mul_busy_c%0d got start=%b a=%h b=%h op=%h rv=%b want 1 ff ff 4 0000",
                                   k, alu_start, alu_a, alu_b, alu_op, rsp_valid);
            end
            step();
        end
        checks++;
        if ({rsp_valid, rsp_result, rsp_err, alu_start} !== {4'b0100, 16'hFE01, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL mul_rsp got rv=%b res=%h err=%b start=%b want 0100 fe01 0 0",
                               rsp_valid, rsp_result, rsp_err, alu_start);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ea [4] = '{8'h3C, 8'hA5, 8'h12, 8'hF0};
        logic [7:0]  eb [4] = '{8'h0F, 8'h5A, 8'h34, 8'h0C};
        logic [15:0] ex [4] = '{16'h0033, 16'h00FF, 16'h0026, 16'h00FC};
        logic [3:0]  exp_oh;
        int t;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) set_req(i, ea[i], eb[i], 3'b011);
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 6; n++) begin
            exp_oh = 4'b0001 << (n % 4);
            t = 0;
            while (req_ready == '0 && t < 10) begin step(); t++; end
            checks++;
            if (req_ready !== exp_oh) begin
                errors++; $display("[TB] FAIL b2b_grant%0d got %b want %b", n, req_ready, exp_oh);
            end
            step();
            t = 0;
            while (rsp_valid == '0 && t < 10) begin step(); t++; end
            if (n == 5) req_valid = '0;
            checks++;
            if (rsp_valid !== exp_oh || rsp_result !== ex[n % 4] || rsp_err !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_rsp%0d got rv=%b res=%h err=%b want %b %h 0",
                                   n, rsp_valid, rsp_result, rsp_err, exp_oh, ex[n % 4]);
            end
            step();
        end
        checks++;
        if (min_gap < 2) begin
            errors++; $display("[TB] FAIL start_gap got %0d want >=2", min_gap);
        end
    endtask

    task automatic test_nop_illegal();
        set_req(1, 8'h12, 8'h34, 3'b000);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL nop_ready got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({rsp_valid, rsp_result, rsp_err, alu_start} !== {4'b0010, 16'h0000, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL nop_rsp got rv=%b res=%h err=%b start=%b want 0010 0000 0 0",
                               rsp_valid, rsp_result, rsp_err, alu_start);
        end
        step();
        set_req(1, 8'h12, 8'h34, 3'b110);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL ill_ready got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({rsp_valid, rsp_result, rsp_err, alu_start} !== {4'b0010, 16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL ill_rsp got rv=%b res=%h err=%b start=%b want 0010 0000 1 0",
                               rsp_valid, rsp_result, rsp_err, alu_start);
        end
        step();
    endtask

    task automatic test_timeout();
        int t;
        alu_kill = 1'b1;
        set_req(0, 8'h01, 8'h02, 3'b001);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL to_ready got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (alu_start !== 1'b1 || rsp_valid !== 4'b0000) begin
                errors++; $display("[TB] FAIL to_busy_c%0d got start=%b rv=%b want 1 0000", k, alu_start, rsp_valid);
            end
            step();
        end
        checks++;
        if ({rsp_valid, rsp_result, rsp_err, alu_start} !== {4'b0001, 16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL to_rsp got rv=%b res=%h err=%b start=%b want 0001 0000 1 0",
                               rsp_valid, rsp_result, rsp_err, alu_start);
        end
        alu_kill = 1'b0;
        step();
        set_req(3, 8'h07, 8'h09, 3'b001);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("[TB] FAIL to_next_ready got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        t = 0;
        while (rsp_valid == '0 && t < 10) begin step(); t++; end
        checks++;
        if ({rsp_valid, rsp_result, rsp_err} !== {4'b1000, 16'h0010, 1'b0}) begin
            errors++; $display("[TB] FAIL to_next_rsp got rv=%b res=%h err=%b want 1000 0010 0",
                               rsp_valid, rsp_result, rsp_err);
        end
        step();
    endtask

    task automatic test_reset_midop();
        logic stray;
        int t;
        set_req(1, 8'h03, 8'h04, 3'b100);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL rst_mul_ready got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        checks++;
        if (alu_start !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_pre_start got %b want 1", alu_start);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({alu_start, busy, rsp_valid} !== 6'b0) begin
            errors++; $display("[TB] FAIL rst_async got start=%b busy=%b rv=%b want 0 0 0000",
                               alu_start, busy, rsp_valid);
        end
        step();
        step();
        reset_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (rsp_valid != '0 || alu_start) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_no_rsp got activity=%b want 0", stray);
        end
        set_req(1, 8'h02, 8'h03, 3'b001);
        set_req(3, 8'h02, 8'h02, 3'b001);
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL rst_ptr_grant got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b1000;
        t = 0;
        while (rsp_valid == '0 && t < 10) begin step(); t++; end
        checks++;
        if ({rsp_valid, rsp_result} !== {4'b0010, 16'h0005}) begin
            errors++; $display("[TB] FAIL rst_r1_rsp got rv=%b res=%h want 0010 0005", rsp_valid, rsp_result);
        end
        step();
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("[TB] FAIL rst_r3_ready got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        t = 0;
        while (rsp_valid == '0 && t < 10) begin step(); t++; end
        checks++;
        if ({rsp_valid, rsp_result, rsp_err} !== {4'b1000, 16'h0004, 1'b0}) begin
            errors++; $display("[TB] FAIL rst_r3_rsp got rv=%b res=%h err=%b want 1000 0004 0",
                               rsp_valid, rsp_result, rsp_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_nop_illegal();
        test_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
